instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Front pipeline stage. Owns the PC, drives the synchronous-read instruction BRAM and delivers
//  {inst, pc, pc1, inst_valid} to decode, which feeds operand fetch. Handles decode stalls,
//  branch/jump redirects from downstream, halt detection and restart.
// PARAMETERS
//  INST_MEM_WIDTH  14            word-address width of instruction memory (pc, pc1, addresses)
//  RESET_PC        '0            PC fetched first after reset or restart
//  HALT_WORD       32'hFFFF_FFFF instruction encoding that halts fetch
// PORTS
//  CLK           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  stall         in   1       decode/hazard stall: hold all outputs, do not advance
//  redirect      in   1       taken branch/jump resolved downstream
//  redirect_pc   in   W       redirect target (W = INST_MEM_WIDTH)
//  restart       in   1       leave HALTED and refetch from RESET_PC
//  imem_addr     out  W       BRAM word address (= fetch_pc register)
//  imem_en       out  1       BRAM read enable; BRAM output holds when low
//  imem_rdata    in   32      BRAM data, valid one cycle after imem_addr/imem_en
//  inst          out  32      instruction to decode (= imem_rdata)
//  inst_valid    out  1       inst/pc/pc1 are a real, non-squashed instruction
//  pc            out  W       word address of inst
//  pc1           out  W       pc + 1, mod 2^W
//  halted        out  1       fetch is in HALTED state
//  fetch_count   out  32      delivered-instruction count (FETCH_PERF_COUNT_EN)
//  bubble_count  out  32      cycles with inst_valid=0 outside HALTED (FETCH_PERF_COUNT_EN)
// BEHAVIOUR
//  Registers: state, fetch_pc, rsp_pc (address of word on imem_rdata), rsp_valid.
//  reset: state=BOOT, fetch_pc=RESET_PC, rsp_pc=0, rsp_valid=0, halted=0, counters=0.
//  Outputs: inst_valid=rsp_valid, pc=rsp_pc, pc1=rsp_pc+1. Latency addr->inst: 1 cycle.
//  States:
//   BOOT: imem_en=1, rsp_pc<=fetch_pc, fetch_pc<=fetch_pc+1, rsp_valid<=1, go RUN. No stall check.
//   RUN: priority redirect > halt > stall > advance:
//    redirect: fetch_pc<=redirect_pc, rsp_valid<=0. Word in flight squashed.
//              1 bubble; target valid 2 cycles after redirect.
//    halt (inst_valid && inst==HALT_WORD && !stall): go HALTED, rsp_valid<=0, imem_en=0.
//              Halt word is delivered exactly once.
//    stall: imem_en=0; fetch_pc, rsp_pc, rsp_valid held. Outputs stable.
//    advance: imem_en=1, rsp_pc<=fetch_pc, fetch_pc<=fetch_pc+1, rsp_valid<=1.
//   HALTED: imem_en=0, inst_valid=0, halted=1; stall/redirect ignored.
//    restart: fetch_pc<=RESET_PC, go BOOT.
//  imem_en=1 also in the redirect cycle. The squashed read completes harmlessly.
//  fetch_pc and pc1 wrap modulo 2^W silently (max addr -> 0).
//  Redirect+stall same cycle: redirect wins and squashes the stalled instruction.
//  Redirect+halt same cycle: redirect wins; no halt (halt word is on the wrong path).
//  reset overrides everything, including mid-stall or mid-redirect.
// CONFIGURATION
//  FETCH_PERF_COUNT_EN defined:
//   fetch_count += 1 each cycle inst_valid && !stall.
//   bubble_count += 1 each cycle !inst_valid && state!=HALTED.
//   Both 32-bit, wrap, clear on reset only.
//  Not defined: fetch_count and bubble_count tied to 0; no counter flops.
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t; HALT_WORD_DEFAULT.
//  Sub-module fetch_perf_counter (two saturating-free counters), instantiated only under the macro.
// TESTING
//  reset, RESET_PC=0, no stall -> imem_addr 0,1,2..; inst_valid rises cycle 2 with pc=0, pc1=1.
//  stall high 3 cycles at pc=5 -> inst/pc/inst_valid unchanged, imem_en=0; pc=6 next after release.
//  redirect to 0x100 while pc=8 -> next cycle inst_valid=0; following cycle pc=0x100 valid.
//  HALT_WORD at pc=3 -> delivered once, then halted=1, inst_valid=0; restart -> pc=0 refetched.
//  redirect and stall same cycle, and redirect with HALT_WORD on output -> redirect taken, no halt.
//  fetch_pc at 2^W-1 -> pc=2^W-1, pc1=0, next pc=0; with macro, counters match valid/bubble tallies.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INST_WIDTH             = 32;
    localparam int unsigned INST_MEM_WIDTH_DEFAULT = 14;
    localparam int unsigned PERF_COUNT_WIDTH       = 32;

    localparam logic [INST_WIDTH-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    // True when a delivered instruction word is the halt encoding.
    function automatic logic is_halt_word(input logic [INST_WIDTH-1:0] word,
                                          input logic [INST_WIDTH-1:0] halt_word);
        return word == halt_word;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Delivered-instruction and bubble counters for the fetch stage.
// Only instantiated when FETCH_PERF_COUNT_EN is defined.
module fetch_perf_counter
    import fetch_pkg::*;
(
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        inc_fetch,
    input  logic                        inc_bubble,
    output logic [PERF_COUNT_WIDTH-1:0] fetch_count,
    output logic [PERF_COUNT_WIDTH-1:0] bubble_count
);

    // Free-running wrap-around counters, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (inc_fetch) begin
                fetch_count <= fetch_count + PERF_COUNT_WIDTH'(1);
            end
            if (inc_bubble) begin
                bubble_count <= bubble_count + PERF_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Front pipeline stage: owns the PC, drives the sync-read instruction BRAM, handles
// stall/redirect/halt/restart. Define FETCH_PERF_COUNT_EN to enable the perf counters.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned                  INST_MEM_WIDTH = INST_MEM_WIDTH_DEFAULT,
    parameter logic [INST_MEM_WIDTH-1:0]    RESET_PC       = '0,
    parameter logic [INST_WIDTH-1:0]        HALT_WORD      = HALT_WORD_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [INST_MEM_WIDTH-1:0]   redirect_pc,
    input  logic                        restart,
    output logic [INST_MEM_WIDTH-1:0]   imem_addr,
    output logic                        imem_en,
    input  logic [INST_WIDTH-1:0]       imem_rdata,
    output logic [INST_WIDTH-1:0]       inst,
    output logic                        inst_valid,
    output logic [INST_MEM_WIDTH-1:0]   pc,
    output logic [INST_MEM_WIDTH-1:0]   pc1,
    output logic                        halted,
    output logic [PERF_COUNT_WIDTH-1:0] fetch_count,
    output logic [PERF_COUNT_WIDTH-1:0] bubble_count
);

    localparam int unsigned W = INST_MEM_WIDTH;

    fetch_state_t state_q, state_d;
    logic [W-1:0] fetch_pc_q, fetch_pc_d;
    logic [W-1:0] rsp_pc_q, rsp_pc_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         halt_hit;

    assign halt_hit = rsp_valid_q && is_halt_word(imem_rdata, HALT_WORD) && !stall;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state and BRAM enable; in RUN the priority is redirect > halt > stall > advance.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        imem_en     = 1'b0;

        unique case (state_q)
            BOOT: begin
                imem_en     = 1'b1;
                rsp_pc_d    = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + W'(1);
                rsp_valid_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // The read issued this cycle is on the wrong path and is dropped.
                    imem_en     = 1'b1;
                    fetch_pc_d  = redirect_pc;
                    rsp_valid_d = 1'b0;
                end else if (halt_hit) begin
                    rsp_valid_d = 1'b0;
                    state_d     = HALTED;
                end else if (stall) begin
                    imem_en = 1'b0;
                end else begin
                    imem_en     = 1'b1;
                    rsp_pc_d    = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + W'(1);
                    rsp_valid_d = 1'b1;
                end
            end
            HALTED: begin
                rsp_valid_d = 1'b0;
                if (restart) begin
                    fetch_pc_d = RESET_PC;
                    state_d    = BOOT;
                end
            end
            default: begin
                state_d     = BOOT;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr  = fetch_pc_q;
    assign inst       = imem_rdata;
    assign inst_valid = rsp_valid_q;
    assign pc         = rsp_pc_q;
    assign pc1        = rsp_pc_q + W'(1);
    assign halted     = (state_q == HALTED);

`ifdef FETCH_PERF_COUNT_EN
    fetch_perf_counter u_perf (
        .CLK          (CLK),
        .reset        (reset),
        .inc_fetch    (rsp_valid_q && !stall),
        .inc_bubble   (!rsp_valid_q && (state_q != HALTED)),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );
`else
    assign fetch_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/redirect/restart/reset traffic checked every cycle against a behavioural model.
module tb_instruction_fetch;

    localparam int unsigned AW = 14;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          CLK;
    logic          reset;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          restart;
    logic [AW-1:0] imem_addr;
    logic          imem_en;
    logic [31:0]   imem_rdata;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc1;
    logic          halted;
    logic [31:0]   fetch_count;
    logic [31:0]   bubble_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0]   mem [0:DEPTH-1];
    logic [AW-1:0] halt_addrs [0:31];

    instruction_fetch dut (
        .CLK          (CLK),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .restart      (restart),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .pc1          (pc1),
        .halted       (halted),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read BRAM that holds its output while disabled.
    always @(posedge CLK) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_known  = 1'b0;
    logic          m_boot   = 1'b0;
    logic          m_halt   = 1'b0;
    logic          m_valid  = 1'b0;
    logic [AW-1:0] m_fetch  = '0;
    logic [AW-1:0] m_pc     = '0;
    logic [31:0]   m_fcnt   = 0;
    logic [31:0]   m_bcnt   = 0;

    always @(negedge CLK) begin
        logic halting;
        logic e_en;
        halting = m_valid && (mem[m_pc] == HALT) && !stall;
        if (m_boot)         e_en = 1'b1;
        else if (m_halt)    e_en = 1'b0;
        else if (redirect)  e_en = 1'b1;
        else if (halting)   e_en = 1'b0;
        else if (stall)     e_en = 1'b0;
        else                e_en = 1'b1;

        if (m_known) begin
            chk("inst_valid", 32'(inst_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
            if (!reset) chk("imem_en", 32'(imem_en), 32'(e_en));
            if (m_valid) begin
                chk("pc", 32'(pc), 32'(m_pc));
                chk("pc1", 32'(pc1), 32'(AW'(m_pc + 1)));
                chk("inst", inst, mem[m_pc]);
            end
`ifdef FETCH_PERF_COUNT_EN
            chk("fetch_count", fetch_count, m_fcnt);
            chk("bubble_count", bubble_count, m_bcnt);
`else
            chk("fetch_count_off", fetch_count, 32'd0);
            chk("bubble_count_off", bubble_count, 32'd0);
`endif
        end

        // Advance the model by one clock given this cycle's inputs.
        if (reset) begin
            m_known = 1'b1;
            m_boot  = 1'b1;
            m_halt  = 1'b0;
            m_valid = 1'b0;
            m_fetch = '0;
            m_pc    = '0;
            m_fcnt  = 0;
            m_bcnt  = 0;
        end else if (m_known) begin
            if (m_valid && !stall) m_fcnt = m_fcnt + 1;
            if (!m_valid && !m_halt) m_bcnt = m_bcnt + 1;
            if (m_boot) begin
                m_pc    = m_fetch;
                m_fetch = AW'(m_fetch + 1);
                m_valid = 1'b1;
                m_boot  = 1'b0;
            end else if (m_halt) begin
                if (restart) begin
                    m_fetch = '0;
                    m_boot  = 1'b1;
                    m_halt  = 1'b0;
                end
            end else if (redirect) begin
                m_fetch = redirect_pc;
                m_valid = 1'b0;
            end else if (halting) begin
                m_halt  = 1'b1;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_pc    = m_fetch;
                m_fetch = AW'(m_fetch + 1);
                m_valid = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pc(input logic [AW-1:0] target);
        int n = 0;
        while (!(inst_valid === 1'b1 && pc === target)) begin
            if (n >= 400) begin
                checks++;
                failures++;
                $display("FAIL wait_pc timeout actual_pc=%h required_pc=%h", pc, target);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        restart     = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0000_0013;
        end
        mem[3]      = HALT;
        mem[14'h205] = HALT;

        step();
        step();
        reset = 1'b0;
        chk("boot_valid", 32'(inst_valid), 32'd0);
        chk("boot_addr", 32'(imem_addr), 32'd0);
        chk("boot_halted", 32'(halted), 32'd0);
        step();
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_pc", 32'(pc), 32'd0);
        chk("first_pc1", 32'(pc1), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd1);

        // Halt word at address 3 is delivered once, then fetch halts.
        wait_pc(AW'(3));
        chk("halt_inst", inst, HALT);
        step();
        chk("halt_state", 32'(halted), 32'd1);
        chk("halt_valid", 32'(inst_valid), 32'd0);
        step();
        step();
        chk("halt_hold", 32'(halted), 32'd1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_boot_valid", 32'(inst_valid), 32'd0);
        chk("restart_boot_halted", 32'(halted), 32'd0);
        step();
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_valid", 32'(inst_valid), 32'd1);
        mem[3] = 32'h0000_0013;

        // Three-cycle stall at pc=5.
        wait_pc(AW'(5));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc), 32'd5);
            chk("stall_valid", 32'(inst_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("stall_release_pc", 32'(pc), 32'd6);

        // Redirect to 0x100 while pc=8.
        wait_pc(AW'(8));
        redirect    = 1'b1;
        redirect_pc = AW'(14'h100);
        step();
        redirect = 1'b0;
        chk("redir_bubble", 32'(inst_valid), 32'd0);
        step();
        chk("redir_pc", 32'(pc), 32'h100);
        chk("redir_valid", 32'(inst_valid), 32'd1);

        // Redirect and stall in the same cycle: redirect wins.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = AW'(14'h200);
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("redir_stall_bubble", 32'(inst_valid), 32'd0);
        step();
        chk("redir_stall_pc", 32'(pc), 32'h200);

        // Redirect while the halt word is on the output: no halt.
        wait_pc(AW'(14'h205));
        chk("wrongpath_halt_inst", inst, HALT);
        redirect    = 1'b1;
        redirect_pc = AW'(14'h300);
        step();
        redirect = 1'b0;
        chk("wrongpath_halted", 32'(halted), 32'd0);
        chk("wrongpath_bubble", 32'(inst_valid), 32'd0);
        step();
        chk("wrongpath_pc", 32'(pc), 32'h300);
        chk("wrongpath_halted2", 32'(halted), 32'd0);

        // Address wrap at the top of instruction memory.
        redirect    = 1'b1;
        redirect_pc = AW'(14'h3FFE);
        step();
        redirect = 1'b0;
        wait_pc(AW'(14'h3FFF));
        chk("wrap_pc1", 32'(pc1), 32'd0);
        step();
        chk("wrap_pc", 32'(pc), 32'd0);

        // Randomized traffic with planted halt words.
        reset = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            halt_addrs[i] = AW'($urandom);
            mem[halt_addrs[i]] = HALT;
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            stall    = ($urandom % 100) < 25;
            redirect = ($urandom % 100) < 8;
            if (($urandom % 100) < 30) redirect_pc = halt_addrs[$urandom % 32];
            else                       redirect_pc = AW'($urandom);
            restart  = ($urandom % 100) < 15;
            reset    = ($urandom % 1000) < 3;
            step();
        end
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        restart  = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
